mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port es_to_ms_valid  input  1  upstream has an instruction this cycle.
REQ-004 SHALL have port es_to_ms_bus  input  77  {mem_req[76], load_op[75:71], res_from_mem[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}.
REQ-005 SHALL have port ms_allowin  output  1  stage can accept an instruction this cycle.
REQ-006 SHALL have port ws_allowin  input  1  downstream can accept.
REQ-007 SHALL have port ms_to_ws_valid  output  1  stage presents a completed instruction.
REQ-008 SHALL have port ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-009 SHALL have port ms_fwd_bus  output  39  {fwd_valid[38], blk_valid[37], dest[36:32], final_result[31:0]}.
REQ-010 SHALL have port data_sram_data_ok  input  1  read/write response for the oldest accepted request.
REQ-011 SHALL have port data_sram_rdata  input  32  read data, valid with data_ok.
REQ-012 SHALL have port ms_flush  input  1  exception/ertn flush, kills the held instruction.

Function
REQ-013 SHALL latch es_to_ms_bus into an internal register when es_to_ms_valid && ms_allowin; ms_valid <= es_to_ms_valid when ms_allowin.
REQ-014 SHALL drive ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush.
REQ-015 SHALL set ms_ready_go = !mem_req || data_ok_now || rdata_buf_vld, where data_ok_now = data_sram_data_ok && cancel_cnt==0.
REQ-016 SHALL capture data_sram_rdata into rdata_buf and set rdata_buf_vld when data_ok_now && ms_valid && mem_req && !ws_allowin; clear rdata_buf_vld when the instruction leaves or on flush.
REQ-017 SHALL select raw = rdata_buf_vld ? rdata_buf : data_sram_rdata; byte/half selected by result[1:0] (half by result[1]).
REQ-018 SHALL extend per load_op one-hot: [0] ld.b sign, [1] ld.h sign, [2] ld.w, [3] ld.bu zero, [4] ld.hu zero.
REQ-019 SHALL set final_result = res_from_mem ? extended load data : result.
REQ-020 SHALL track outstanding requests: pending set when a mem_req instruction is latched, cleared on data_ok_now.
REQ-021 On ms_flush SHALL clear ms_valid and rdata_buf_vld next cycle; if pending and no data_ok_now in that cycle, SHALL increment 2-bit cancel_cnt.
REQ-022 SHALL decrement cancel_cnt on each data_sram_data_ok while cancel_cnt!=0 and discard that data; flush and decrement in the same cycle net to no change.
REQ-023 SHALL ignore data_sram_data_ok when ms_valid==0 and cancel_cnt==0.
REQ-024 SHALL drive fwd_valid = ms_valid && gr_we && ms_ready_go.
REQ-025 SHALL hold ms_valid and all bus contents stable while ms_valid && !(ms_ready_go && ws_allowin).

Reset
REQ-026 SHALL on reset clear ms_valid, rdata_buf_vld, pending, cancel_cnt; ms_to_ws_valid=0, ms_allowin=1, fwd_valid=0, blk_valid=0 immediately (asynchronous).
REQ-027 Reset mid-transaction SHALL drop the in-flight instruction; data_ok arriving after reset deassert SHALL be ignored per REQ-023.

Configuration
REQ-028 With MS_LOAD_FWD_EN defined, blk_valid = ms_valid && res_from_mem && !ms_ready_go, so load data forwards in the data_ok cycle.
REQ-029 Without MS_LOAD_FWD_EN, blk_valid = ms_valid && res_from_mem for the whole residency; fwd_valid SHALL be 0 for loads.

Verification
REQ-030 ALU op result=0x1234_5678, gr_we=1, ws_allowin=1 -> ms_to_ws_valid in the cycle after acceptance, final_result 0x1234_5678.
REQ-031 ld.b addr low 2'b11, rdata 0x80FF_FF11 -> final_result 0xFFFF_FF80; ld.hu addr 2'b10, same rdata -> 0x0000_80FF.
REQ-032 ld.w, data_ok with rdata 0xDEAD_BEEF while ws_allowin=0 for 3 cycles -> rdata_buf holds, ms_to_ws_valid=1 all 3 cycles, result 0xDEAD_BEEF on release.
REQ-033 ld.w latched, ms_flush before data_ok -> ms_valid=0, cancel_cnt=1; next data_ok discarded; next load's data_ok accepted normally.
REQ-034 Assert reset while ld.w awaits data_ok -> all outputs at reset values same cycle; subsequent stray data_ok produces no ms_to_ws_valid.

Source files
------------

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Handshake and bus bundle between the execute stage, the
//                memory stage, the writeback stage and the data SRAM
//                response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic [76:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_fwd_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_flush;

    // Memory stage side
    modport master (
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  ws_allowin,
        input  data_sram_data_ok,
        input  data_sram_rdata,
        input  ms_flush,
        output ms_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        output ms_fwd_bus
    );

    // Surrounding pipeline / memory side
    modport slave (
        output es_to_ms_valid,
        output es_to_ms_bus,
        output ws_allowin,
        output data_sram_data_ok,
        output data_sram_rdata,
        output ms_flush,
        input  ms_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        input  ms_fwd_bus
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory pipeline stage. Holds one instruction, waits for the
//                data SRAM response of loads/stores, buffers read data while
//                writeback stalls, aligns and extends load data, cancels
//                responses that belong to flushed instructions, and drives
//                the forwarding/blocking bus.
//  Options     : MS_LOAD_FWD_EN - when defined, load results forward in the
//                data_ok cycle; otherwise loads block for their whole
//                residency and never forward.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  wire             clk,
    input  wire             reset,
    mem_stage_if.master     ms_if
);

    // ------------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------------
    logic        r_ms_valid;
    logic [76:0] r_es_bus;
    logic [31:0] r_rdata_buf;
    logic        r_rdata_buf_vld;
    logic        r_pending;
    logic [1:0]  r_cancel_cnt;

    // ------------------------------------------------------------------------
    // Field decode of the held instruction
    // ------------------------------------------------------------------------
    logic        w_mem_req;
    logic [4:0]  w_load_op;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_result;
    logic [31:0] w_pc;

    assign w_mem_req      = r_es_bus[76];
    assign w_load_op      = r_es_bus[75:71];
    assign w_res_from_mem = r_es_bus[70];
    assign w_gr_we        = r_es_bus[69];
    assign w_dest         = r_es_bus[68:64];
    assign w_result       = r_es_bus[63:32];
    assign w_pc           = r_es_bus[31:0];

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_data_ok_now;
    logic w_ms_ready_go;
    logic w_ms_allowin;
    logic w_leave;
    logic w_accept;

    // A response only belongs to the held instruction once all responses of
    // previously flushed requests have drained.
    assign w_data_ok_now  = ms_if.data_sram_data_ok && (r_cancel_cnt == 2'd0);
    assign w_ms_ready_go  = !w_mem_req || w_data_ok_now || r_rdata_buf_vld;
    assign w_ms_allowin   = !r_ms_valid || (w_ms_ready_go && ms_if.ws_allowin);
    assign w_leave        = r_ms_valid && w_ms_ready_go && ms_if.ws_allowin;
    assign w_accept       = ms_if.es_to_ms_valid && w_ms_allowin;

    assign ms_if.ms_allowin     = w_ms_allowin;
    assign ms_if.ms_to_ws_valid = r_ms_valid && w_ms_ready_go && !ms_if.ms_flush;

    // ------------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------------
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;

    assign w_raw  = r_rdata_buf_vld ? r_rdata_buf : ms_if.data_sram_rdata;
    assign w_half = w_result[1] ? w_raw[31:16] : w_raw[15:0];

    // Pick the addressed byte lane
    always_comb begin
        w_byte = w_raw[7:0];
        case (w_result[1:0])
            2'b00:   w_byte = w_raw[7:0];
            2'b01:   w_byte = w_raw[15:8];
            2'b10:   w_byte = w_raw[23:16];
            default: w_byte = w_raw[31:24];
        endcase
    end

    // Extend according to the one-hot load opcode; word load is the fallback
    always_comb begin
        w_load_data = w_raw;
        if (w_load_op[0]) begin
            w_load_data = {{24{w_byte[7]}}, w_byte};
        end else if (w_load_op[1]) begin
            w_load_data = {{16{w_half[15]}}, w_half};
        end else if (w_load_op[3]) begin
            w_load_data = {24'd0, w_byte};
        end else if (w_load_op[4]) begin
            w_load_data = {16'd0, w_half};
        end
    end

    assign w_final_result = w_res_from_mem ? w_load_data : w_result;

    assign ms_if.ms_to_ws_bus = {w_gr_we, w_dest, w_final_result, w_pc};

    // ------------------------------------------------------------------------
    // Forwarding / blocking
    // ------------------------------------------------------------------------
    logic w_fwd_valid;
    logic w_blk_valid;

`ifdef MS_LOAD_FWD_EN
    assign w_fwd_valid = r_ms_valid && w_gr_we && w_ms_ready_go;
    assign w_blk_valid = r_ms_valid && w_res_from_mem && !w_ms_ready_go;
`else
    assign w_fwd_valid = r_ms_valid && w_gr_we && w_ms_ready_go && !w_res_from_mem;
    assign w_blk_valid = r_ms_valid && w_res_from_mem;
`endif

    assign ms_if.ms_fwd_bus = {w_fwd_valid, w_blk_valid, w_dest, w_final_result};

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------

    // Stage valid bit: flush kills the held instruction, otherwise refill on allowin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ms_if.ms_flush) begin
            r_ms_valid <= 1'b0;
        end else if (w_ms_allowin) begin
            r_ms_valid <= ms_if.es_to_ms_valid;
        end
    end

    // Instruction payload register, only written on acceptance so it holds during stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_bus <= 77'd0;
        end else if (w_accept) begin
            r_es_bus <= ms_if.es_to_ms_bus;
        end
    end

    // Keep read data that arrived while writeback was stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata_buf_vld <= 1'b0;
            r_rdata_buf     <= 32'd0;
        end else if (ms_if.ms_flush || w_leave) begin
            r_rdata_buf_vld <= 1'b0;
        end else if (w_data_ok_now && r_ms_valid && w_mem_req && !ms_if.ws_allowin) begin
            r_rdata_buf_vld <= 1'b1;
            r_rdata_buf     <= ms_if.data_sram_rdata;
        end
    end

    // Outstanding request of the held instruction; on flush its response is
    // handed over to the cancel counter instead
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (ms_if.ms_flush) begin
            r_pending <= 1'b0;
        end else if (w_accept && ms_if.es_to_ms_bus[76]) begin
            r_pending <= 1'b1;
        end else if (w_data_ok_now) begin
            r_pending <= 1'b0;
        end
    end

    // Count responses still owed to flushed instructions; a flush and a
    // discarded response in the same cycle cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cancel_cnt <= 2'd0;
        end else begin
            case ({ms_if.ms_flush && r_pending && !w_data_ok_now && (r_cancel_cnt != 2'd3),
                   ms_if.data_sram_data_ok && (r_cancel_cnt != 2'd0)})
                2'b10:   r_cancel_cnt <= r_cancel_cnt + 2'd1;
                2'b01:   r_cancel_cnt <= r_cancel_cnt - 2'd1;
                default: r_cancel_cnt <= r_cancel_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Scoreboard bench for mem_stage. Directed stimulus pushes the
//                expected writeback bus into a queue; a monitor pops and
//                compares whenever an instruction is handed to writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic clk;
    logic reset;
    mem_stage_if m ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .ms_if (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [69:0] exp_q[$];

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [76:0] mk(input logic mr, input logic [4:0] op, input logic rfm,
                                       input logic we, input logic [4:0] d,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {mr, op, rfm, we, d, res, pc};
    endfunction

    // Monitor: every hand-off to writeback must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && m.ms_to_ws_valid && m.ws_allowin) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h expected none", m.ms_to_ws_bus);
            end else begin
                chk("ws_bus", m.ms_to_ws_bus, exp_q.pop_front());
            end
        end
    end

    // Present an instruction and hold it until the stage takes it
    task automatic issue(input logic [76:0] b);
        int budget;
        budget = 50;
        m.es_to_ms_valid = 1'b1;
        m.es_to_ms_bus   = b;
        @(negedge clk);
        while (!m.ms_allowin && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got allowin 0 expected 1");
        end
        @(posedge clk);
        #1;
        m.es_to_ms_valid = 1'b0;
    endtask

    // Issue a load and answer it after 'delay' idle cycles
    task automatic do_load(input logic [4:0] op, input logic [1:0] lo, input logic [31:0] rdata,
                           input logic [31:0] exp, input logic [4:0] d, input int delay);
        logic [31:0] pc;
        pc = 32'h1c00_0100 + {27'd0, d, 2'b00};
        exp_q.push_back({1'b1, d, exp, pc});
        issue(mk(1'b1, op, 1'b1, 1'b1, d, {30'h0400_0000, lo}, pc));
        @(negedge clk);
        chk("load_wait_valid", {69'd0, m.ms_to_ws_valid}, 70'd0);
        chk("load_wait_blk", {69'd0, m.ms_fwd_bus[37]}, 70'd1);
        repeat (delay) @(posedge clk);
        @(posedge clk);
        #1;
        m.data_sram_data_ok = 1'b1;
        m.data_sram_rdata   = rdata;
        @(posedge clk);
        #1;
        m.data_sram_data_ok = 1'b0;
        m.data_sram_rdata   = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        reset               = 1'b1;
        m.es_to_ms_valid    = 1'b0;
        m.es_to_ms_bus      = '0;
        m.ws_allowin        = 1'b1;
        m.data_sram_data_ok = 1'b0;
        m.data_sram_rdata   = 32'h0;
        m.ms_flush          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_allowin", {69'd0, m.ms_allowin}, 70'd1);
        chk("rst_valid", {69'd0, m.ms_to_ws_valid}, 70'd0);
        chk("rst_fwd_blk", {68'd0, m.ms_fwd_bus[38:37]}, 70'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ALU result passes through in the cycle after acceptance
        exp_q.push_back({1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000});
        issue(mk(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000));
        @(negedge clk);
        chk("alu_valid", {69'd0, m.ms_to_ws_valid}, 70'd1);
        chk("alu_fwd", {31'd0, m.ms_fwd_bus}, {31'd0, 1'b1, 1'b0, 5'd5, 32'h1234_5678});
        @(posedge clk);
        #1;

        // Byte/half alignment and extension
        do_load(5'b00001, 2'b11, 32'h80FF_FF11, 32'hFFFF_FF80, 5'd6, 0);
        do_load(5'b10000, 2'b10, 32'h80FF_FF11, 32'h0000_80FF, 5'd7, 2);
        do_load(5'b00010, 2'b00, 32'h1234_8001, 32'hFFFF_8001, 5'd8, 0);
        do_load(5'b01000, 2'b01, 32'h1234_8001, 32'h0000_0080, 5'd9, 1);

        // Word load answered while writeback stalls for three cycles
        exp_q.push_back({1'b1, 5'd10, 32'hDEAD_BEEF, 32'h1c00_0200});
        issue(mk(1'b1, 5'b00100, 1'b1, 1'b1, 5'd10, 32'h0400_0010, 32'h1c00_0200));
        m.ws_allowin        = 1'b0;
        m.data_sram_data_ok = 1'b1;
        m.data_sram_rdata   = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {69'd0, m.ms_to_ws_valid}, 70'd1);
            chk("stall_allowin", {69'd0, m.ms_allowin}, 70'd0);
            @(posedge clk);
            #1;
            m.data_sram_data_ok = 1'b0;
            m.data_sram_rdata   = 32'h5555_AAAA;
        end
        chk("stall_result", {38'd0, m.ms_fwd_bus[31:0]}, {38'd0, 32'hDEAD_BEEF});
`ifdef MS_LOAD_FWD_EN
        chk("stall_fwd", {69'd0, m.ms_fwd_bus[38]}, 70'd1);
`else
        chk("stall_fwd", {69'd0, m.ms_fwd_bus[38]}, 70'd0);
`endif
        m.ws_allowin = 1'b1;
        @(posedge clk);
        #1;

        // Flush before the response: the late response is discarded
        issue(mk(1'b1, 5'b00100, 1'b1, 1'b1, 5'd11, 32'h0400_0020, 32'h1c00_0300));
        m.ms_flush = 1'b1;
        @(negedge clk);
        chk("flush_valid", {69'd0, m.ms_to_ws_valid}, 70'd0);
        @(posedge clk);
        #1;
        m.ms_flush = 1'b0;
        @(negedge clk);
        chk("flush_allowin", {69'd0, m.ms_allowin}, 70'd1);
        chk("flush_cancel_cnt", {68'd0, dut.r_cancel_cnt}, 70'd1);
        @(posedge clk);
        #1;
        m.data_sram_data_ok = 1'b1;
        m.data_sram_rdata   = 32'h0000_0BAD;
        @(negedge clk);
        chk("cancel_valid", {69'd0, m.ms_to_ws_valid}, 70'd0);
        @(posedge clk);
        #1;
        m.data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("cancel_drained", {68'd0, dut.r_cancel_cnt}, 70'd0);
        @(posedge clk);
        #1;
        do_load(5'b00100, 2'b00, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd12, 0);

        // Reset while a load waits: outputs return to reset values at once
        issue(mk(1'b1, 5'b00100, 1'b1, 1'b1, 5'd13, 32'h0400_0030, 32'h1c00_0400));
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_allowin", {69'd0, m.ms_allowin}, 70'd1);
        chk("midrst_valid", {69'd0, m.ms_to_ws_valid}, 70'd0);
        chk("midrst_fwd_blk", {68'd0, m.ms_fwd_bus[38:37]}, 70'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        m.data_sram_data_ok = 1'b1;
        m.data_sram_rdata   = 32'h1111_2222;
        @(negedge clk);
        chk("stray_ok_valid", {69'd0, m.ms_to_ws_valid}, 70'd0);
        @(posedge clk);
        #1;
        m.data_sram_data_ok = 1'b0;

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("scoreboard_drained", 70'(exp_q.size()), 70'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
